// File: rtl/sat_event_pkg.sv
// sat_event_pkg: shared FSM state, event code and event record types for the saturating-counter event reporter.
package sat_event_pkg;
   localparam int WIDTH = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, ABOVE = 2'd1, FULL = 2'd2} state_t;
   typedef enum logic [1:0] {EV_THRESH = 2'd0, EV_FULL = 2'd1, EV_RESTART = 2'd2} code_t;
   typedef struct packed {
      code_t            code;
      logic [WIDTH-1:0] value;
   } event_t;
endpackage

// File: rtl/sat_event_if.sv
// sat_event_if: event drain bus; valid/ready handshake with code/value payload plus drop count and FSM state for debug.
//   master (reporter): drives valid, code, value, drops, state; samples ready
//   slave (consumer):  samples valid, code, value, drops, state; drives ready
interface sat_event_if #(parameter int WIDTH = 8, parameter int DROP_W = 8);
   logic              valid;
   logic              ready;
   logic [1:0]        code;
   logic [WIDTH-1:0]  value;
   logic [DROP_W-1:0] drops;
   logic [1:0]        state;
   modport master(output valid, code, value, drops, state, input ready);
   modport slave(input valid, code, value, drops, state, output ready);
endinterface

// File: rtl/sat_event_reporter_fifo.sv
// evt_fifo: first-word-fall-through event queue with an extra pointer bit to tell full from empty.
//   i_clk, i_rstn : clock, async active-low reset (clears pointers only)
//   push, din     : write din at tail; caller guarantees !full || pop
//   pop           : drop head; caller guarantees !empty
//   full, empty   : occupancy flags
//   head          : entry at read pointer, meaningful while !empty
module evt_fifo
   import sat_event_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = event_t
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic push,
   input  logic pop,
   input  T     din,
   output logic full,
   output logic empty,
   output T     head
);
   localparam int AW = $clog2(DEPTH);
   T mem [DEPTH];
   logic [AW:0] wr_q, rd_q;
   assign empty = wr_q == rd_q;
   assign full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
   assign head  = mem[rd_q[AW-1:0]];
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + (AW + 1)'(1);
         if (pop) rd_q <= rd_q + (AW + 1)'(1);
      end
   end
   // Storage needs no reset: nothing is visible until a push makes the queue non-empty.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_q[AW-1:0]] <= din;
   end
   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn) push |-> !full || pop);
   a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rstn) pop |-> !empty);
endmodule

// File: rtl/sat_event_reporter.sv
// sat_event_reporter: turns saturating-counter count/full into THRESH/FULL/RESTART events queued for a valid/ready consumer.
//   i_clk, i_rstn : clock, async active-low reset
//   i_count       : upstream counter value
//   i_full        : upstream full flag (all-ones count)
//   i_thresh      : crossing threshold, tracked live while IDLE and held otherwise
//   evt           : event bus (valid/ready, code, value, saturating drop count, FSM state)
module sat_event_reporter
   import sat_event_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [WIDTH-1:0] i_count,
   input  logic             i_full,
   input  logic [WIDTH-1:0] i_thresh,
   sat_event_if.master      evt
);
   typedef struct packed {
      code_t            code;
      logic [WIDTH-1:0] value;
   } ev_t;
   state_t            state_q, state_d;
   code_t             ev_code, last_q;
   logic [WIDTH-1:0]  thresh_q, thr;
   logic [DROP_W-1:0] drops_q;
   logic              below, ev_push, fifo_push, pop, fifo_full, fifo_empty;
   ev_t               head;
   // The threshold follows i_thresh while IDLE so a crossing is judged against the value seen that cycle.
   assign thr   = state_q == IDLE ? i_thresh : thresh_q;
   assign below = i_count < thr;
   always_comb begin
      state_d = state_q;
      ev_push = 1'b0;
      ev_code = EV_THRESH;
      case (state_q)
         IDLE: begin
            if (i_full) begin
               state_d = FULL;
               ev_push = 1'b1;
               ev_code = EV_FULL;
            end else if (!below) begin
               state_d = ABOVE;
               ev_push = 1'b1;
            end
         end
         ABOVE: begin
            if (below) begin
               state_d = IDLE;
               ev_push = 1'b1;
               ev_code = EV_RESTART;
            end else if (i_full) begin
               state_d = FULL;
               ev_push = 1'b1;
               ev_code = EV_FULL;
            end
         end
         FULL: begin
            if (below) begin
               state_d = IDLE;
               ev_push = 1'b1;
               ev_code = EV_RESTART;
            end else if (!i_full) begin
               state_d = ABOVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // A pop in the same cycle frees the head slot, so a push into a full queue still lands.
   assign pop       = evt.valid && evt.ready;
   assign fifo_push = ev_push && (!fifo_full || pop);
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q  <= IDLE;
         thresh_q <= '0;
         drops_q  <= '0;
         last_q   <= EV_THRESH;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) thresh_q <= i_thresh;
         if (ev_push && !fifo_push && drops_q != '1) drops_q <= drops_q + DROP_W'(1);
         if (ev_push) last_q <= ev_code;
      end
   end
   evt_fifo #(.DEPTH(DEPTH), .T(ev_t)) u_fifo (
      .i_clk (i_clk),
      .i_rstn(i_rstn),
      .push  (fifo_push),
      .pop   (pop),
      .din   ('{code: ev_code, value: i_count}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );
   assign evt.valid = !fifo_empty;
   assign evt.code  = fifo_empty ? 2'd0 : head.code;
   assign evt.value = fifo_empty ? '0 : head.value;
   assign evt.drops = drops_q;
   assign evt.state = state_q;
   a_hold: assert property (@(posedge i_clk) disable iff (!i_rstn)
      evt.valid && !evt.ready |=> evt.valid && $stable(evt.code) && $stable(evt.value));
   a_code: assert property (@(posedge i_clk) disable iff (!i_rstn) evt.code != 2'd3);
   a_state: assert property (@(posedge i_clk) disable iff (!i_rstn) state_q != 2'd3);
   a_drops_mono: assert property (@(posedge i_clk) disable iff (!i_rstn) 1'b1 |=> drops_q >= $past(drops_q));
   a_drops_sat: assert property (@(posedge i_clk) disable iff (!i_rstn) drops_q == '1 |=> drops_q == '1);
   a_full_last: assert property (@(posedge i_clk) disable iff (!i_rstn) state_q == FULL |-> last_q == EV_FULL);
endmodule
